// File: rtl/bus_pkg.sv
// Shared definitions for the multi-phase bus: phase encoding consumed by the
// initiator, the phase monitor and the e-side checker, plus default parameters.
package bus_pkg;

  // Phase encoding is fixed; the monitor and checker decode these exact values.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARBI     = 3'd1,
    PREAMBLE = 3'd2,
    ADDRESS  = 3'd3,
    DATA     = 3'd4
  } state_t;

  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_LEN_W           = 4;
  localparam int DEF_PREAMBLE_CYCLES = 4;
  localparam int DEF_ARB_TIMEOUT     = 32;

  // Width of a counter that must hold 0 .. max(a,b)-1 (at least one bit).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Command, write-data and bus-side signals of the bus initiator.
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; valid may be raised independently of ready, and the offering side
// holds its payload stable until the transfer happens.
interface bus_initiator_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  // write-data channel
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  // bus side
  logic              bus_req;
  logic              bus_gnt;
  state_t            bus_state;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              done;
  logic              err;

  // Initiator view.
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, bus_gnt,
    output cmd_ready, wr_ready, bus_req, bus_state, bus_addr, bus_valid,
           bus_data, done, err
  );

  // Environment view (command source, data source, arbiter, monitor).
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, bus_gnt,
    input  cmd_ready, wr_ready, bus_req, bus_state, bus_addr, bus_valid,
           bus_data, done, err
  );

endinterface

// File: rtl/bus_initiator.sv
// Active end of the multi-phase bus. Takes one burst command, arbitrates,
// sends a fixed preamble and one address cycle, then streams len+1 data beats
// from the write-data handshake. bus_state exposes the FSM directly.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int LEN_W           = DEF_LEN_W,
  parameter int PREAMBLE_CYCLES = DEF_PREAMBLE_CYCLES,
  parameter int ARB_TIMEOUT     = DEF_ARB_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_initiator_if.master bus
);

  // One phase counter serves both the ARBI timeout and the PREAMBLE length.
  localparam int CNT_W = cnt_width(ARB_TIMEOUT, PREAMBLE_CYCLES);
  localparam logic [CNT_W-1:0] ARB_LAST = CNT_W'(ARB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [LEN_W:0]     beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               bus_req_q, bus_req_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cmd_accept;
  logic               arb_expire;
  logic               beat_xfer;
  logic               last_beat;

  assign cmd_accept = (state_q == IDLE) && bus.cmd_valid;
  // Grant wins over a timeout landing in the same cycle.
  assign arb_expire = (state_q == ARBI) && !bus.bus_gnt && (phase_cnt_q == ARB_LAST);
  assign beat_xfer  = (state_q == DATA) && bus.wr_valid;
  assign last_beat  = beat_xfer && (beat_cnt_q == {1'b0, len_q});

  // State, counters, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cmd_ready_q <= 1'b1;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cmd_ready_q <= cmd_ready_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next phase, counter updates and command capture.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          addr_d      = bus.cmd_addr;
          len_d       = bus.cmd_len;
          phase_cnt_d = '0;
          state_d     = ARBI;
        end
      end
      ARBI: begin
        if (bus.bus_gnt) begin
          phase_cnt_d = '0;
          state_d     = PREAMBLE;
        end else if (arb_expire) begin
          phase_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          phase_cnt_d = phase_cnt_q + CNT_W'(1);
        end
      end
      PREAMBLE: begin
        if (phase_cnt_q == PRE_LAST) begin
          phase_cnt_d = '0;
          state_d     = ADDRESS;
        end else begin
          phase_cnt_d = phase_cnt_q + CNT_W'(1);
        end
      end
      ADDRESS: begin
        beat_cnt_d = '0;
        state_d    = DATA;
      end
      DATA: begin
        if (last_beat) begin
          beat_cnt_d = '0;
          state_d    = IDLE;
        end else if (beat_xfer) begin
          beat_cnt_d = beat_cnt_q + (LEN_W + 1)'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next phase.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    bus_req_d   = (state_d != IDLE);
    bus_addr_d  = ((state_d == ADDRESS) || (state_d == DATA)) ? addr_q : '0;
    done_d      = last_beat;
    err_d       = arb_expire;
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_state = state_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Data path is combinational so a stalled beat never reaches the bus.
  assign bus.wr_ready  = (state_q == DATA);
  assign bus.bus_valid = beat_xfer;
  assign bus.bus_data  = beat_xfer ? bus.wr_data : '0;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: each scenario task drives inputs on the
// falling edge and compares the full output vector 1 ns later.
module tb_bus_initiator;
  import bus_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int PRE    = 4;
  localparam int ARB_TO = 32;

  // {state, req, addr, valid, data, wr_ready, cmd_ready, done, err}
  typedef logic [56:0] obs_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus_if ();

  bus_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .PREAMBLE_CYCLES(PRE), .ARB_TIMEOUT(ARB_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observed();
    return {bus_if.bus_state, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_valid,
            bus_if.bus_data, bus_if.wr_ready, bus_if.cmd_ready, bus_if.done, bus_if.err};
  endfunction

  // Expected outputs from the expected phase and the driven write inputs.
  function automatic obs_t expect_vec(state_t s, logic [15:0] a, logic wv,
                                      logic [31:0] wd, logic dn, logic er);
    logic v;
    v = (s == DATA) && wv;
    return {s, (s != IDLE), ((s == ADDRESS) || (s == DATA)) ? a : 16'h0, v,
            v ? wd : 32'h0, (s == DATA), (s == IDLE), dn, er};
  endfunction

  // Expected phase at cycle i when the command is accepted at cycle 0, the
  // grant is seen in cycle g and DATA lasts dcyc cycles.
  function automatic state_t model_state(int i, int g, int dcyc);
    if (i <= 0)                  return IDLE;
    if (i <= g)                  return ARBI;
    if (i <= g + PRE)            return PREAMBLE;
    if (i == g + PRE + 1)        return ADDRESS;
    if (i <= g + PRE + 1 + dcyc) return DATA;
    return IDLE;
  endfunction

  // driver tasks
  task automatic drive_cmd(logic v, logic [15:0] a, logic [3:0] l);
    bus_if.cmd_valid = v;
    bus_if.cmd_addr  = a;
    bus_if.cmd_len   = l;
  endtask

  task automatic drive_wr(logic v, logic [31:0] d);
    bus_if.wr_valid = v;
    bus_if.wr_data  = d;
  endtask

  task automatic test_reset;
    obs_t exp;
    rst_n = 1'b0;
    drive_cmd(1'b0, 16'h0, 4'h0);
    drive_wr(1'b1, 32'hFFFF_FFFF);
    bus_if.bus_gnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp = expect_vec(IDLE, 16'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL reset_hold got=%h expected=%h", observed(), exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL reset_release got=%h expected=%h", observed(), exp);
    end
  endtask

  task automatic test_basic;
    state_t s;
    obs_t   exp;
    logic [31:0] wd;
    int nvalid = 0;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      drive_cmd(i == 0, (i == 0) ? 16'h1234 : 16'hFFFF, 4'd3);
      bus_if.bus_gnt = (i == 2);
      s  = model_state(i, 2, 4);
      wd = (s == DATA) ? 32'hA0 + 32'(i - 8) : 32'hDEAD_0000 + 32'(i);
      drive_wr(1'b1, wd);
      #1;
      exp = expect_vec(s, 16'h1234, 1'b1, wd, i == 12, 1'b0);
      if (bus_if.bus_valid) nvalid++;
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL basic cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
    checks++;
    if (nvalid !== 4) begin
      failures++;
      $display("FAIL basic_beats got=%0d expected=4", nvalid);
    end
  endtask

  task automatic test_arb_timeout;
    state_t s;
    obs_t   exp;
    for (int i = 0; i <= 34; i++) begin
      @(negedge clk);
      drive_cmd(i == 0, 16'h2222, 4'd2);
      bus_if.bus_gnt = 1'b0;
      drive_wr(1'b1, 32'h5555_5555);
      s = (i >= 1 && i <= ARB_TO) ? ARBI : IDLE;
      #1;
      exp = expect_vec(s, 16'h2222, 1'b1, 32'h5555_5555, 1'b0, i == ARB_TO + 1);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL arb_timeout cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_grant_at_timeout;
    state_t s;
    obs_t   exp;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      drive_cmd(i == 0, 16'h3333, 4'd0);
      bus_if.bus_gnt = (i == ARB_TO);
      drive_wr(1'b1, 32'h0000_C0DE);
      s = model_state(i, ARB_TO, 1);
      #1;
      exp = expect_vec(s, 16'h3333, 1'b1, 32'h0000_C0DE, i == 39, 1'b0);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL grant_at_timeout cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_stalls;
    state_t s;
    obs_t   exp;
    logic   wv;
    logic [31:0] wd;
    int nvalid = 0;
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      drive_cmd(i == 0, 16'h4444, 4'd1);
      bus_if.bus_gnt = (i == 1);
      wv = !(i == 8 || i == 9);
      wd = (i == 7) ? 32'hB0 : (i == 10) ? 32'hB1 : 32'h1111_0000 + 32'(i);
      drive_wr(wv, wd);
      s = model_state(i, 1, 4);
      #1;
      exp = expect_vec(s, 16'h4444, wv, wd, i == 11, 1'b0);
      if (bus_if.bus_valid) nvalid++;
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL stalls cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
    checks++;
    if (nvalid !== 2) begin
      failures++;
      $display("FAIL stalls_beats got=%0d expected=2", nvalid);
    end
  endtask

  task automatic test_back_to_back;
    state_t s;
    obs_t   exp;
    logic [15:0] ea;
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      if (i == 0) drive_cmd(1'b1, 16'h4321, 4'd1);
      else        drive_cmd(i <= 9, 16'h0BEE, 4'd0);
      bus_if.bus_gnt = (i == 1 || i == 10);
      drive_wr(1'b1, 32'hE000 + 32'(i));
      s  = (i <= 9) ? model_state(i, 1, 2) : model_state(i - 9, 1, 1);
      ea = (i < 9) ? 16'h4321 : 16'h0BEE;
      #1;
      exp = expect_vec(s, ea, 1'b1, 32'hE000 + 32'(i), (i == 9 || i == 17), 1'b0);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_reset_mid_data;
    state_t s;
    obs_t   exp;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      drive_cmd(i == 0, 16'h6666, 4'd3);
      bus_if.bus_gnt = (i == 1);
      drive_wr(1'b1, 32'h600 + 32'(i));
      s = model_state(i, 1, 4);
      #1;
      exp = expect_vec(s, 16'h6666, 1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL pre_reset cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
    // assert reset between clock edges during the second beat
    #1 rst_n = 1'b0;
    #1;
    exp = expect_vec(IDLE, 16'h6666, 1'b1, 32'h608, 1'b0, 1'b0);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL async_reset got=%h expected=%h", observed(), exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      drive_cmd(i == 0, 16'h7777, 4'd0);
      bus_if.bus_gnt = (i == 1);
      drive_wr(1'b1, 32'h700 + 32'(i));
      s = model_state(i, 1, 1);
      #1;
      exp = expect_vec(s, 16'h7777, 1'b1, 32'h700 + 32'(i), i == 8, 1'b0);
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL post_reset cycle=%0d got=%h expected=%h", i, observed(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arb_timeout();
    test_grant_at_timeout();
    test_stalls();
    test_back_to_back();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Drives the multi-phase bus whose observed phase sequence is IDLE → ARBI → PREAMBLE → ADDRESS → DATA → IDLE. It is the active end of the bus whose passive end is the phase monitor. It accepts one burst command at a time, requests and waits for arbitration grant, emits a fixed-length preamble and one address cycle, then streams the burst's data beats from a write-data handshake. Its `bus_state` and `bus_valid` outputs use the same encoding the monitor and the e-side checker consume, so enum alignment is a hard requirement.

## Interface
Parameters:
- `ADDR_W`, 16: bus address width.
- `DATA_W`, 32: bus data width.
- `LEN_W`, 4: burst length field width; the burst carries `len+1` beats, so 1..16 beats.
- `PREAMBLE_CYCLES`, 4: cycles spent in PREAMBLE. Legal range is ≥1.
- `ARB_TIMEOUT`, 32: maximum number of ARBI cycles before abort. Legal range is ≥1.

Ports:
- `clk`  in  1  bus clock; all logic on posedge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both are high.
- `cmd_addr`  in  ADDR_W  burst address.
- `cmd_len`  in  LEN_W  beats minus one.
- `wr_valid`  in  1  write beat offered.
- `wr_ready`  out  1  beat accepted when both are high.
- `wr_data`  in  DATA_W  beat payload.
- `bus_req`  out  1  arbitration request.
- `bus_gnt`  in  1  arbitration grant.
- `bus_state`  out  state_t  current phase.
- `bus_addr`  out  ADDR_W  address; valid in ADDRESS and DATA.
- `bus_valid`  out  1  data beat on bus this cycle.
- `bus_data`  out  DATA_W  beat payload.
- `done`  out  1  one-cycle pulse when a burst completes.
- `err`  out  1  one-cycle pulse on arbitration timeout.

## Operation
- The FSM uses `state_t`. The states are IDLE, ARBI, PREAMBLE, ADDRESS, DATA. There is one phase counter, and one beat counter of width LEN_W+1.
- **IDLE:**
  - `cmd_ready`=1.
  - On accept, latch `cmd_addr` and `cmd_len`, then go to ARBI.
- **ARBI:**
  - `bus_req`=1. Count cycles.
  - If `bus_gnt`=1, go to PREAMBLE.
  - Otherwise, on the ARB_TIMEOUT-th ARBI cycle, go to IDLE, pulse `err`, and drop `bus_req`.
  - If `bus_gnt` arrives in the timeout cycle, grant wins and no `err` is raised.
- **PREAMBLE:** stay exactly PREAMBLE_CYCLES cycles, then go to ADDRESS. `bus_gnt` is not re-sampled.
- **ADDRESS:** stay exactly one cycle, driving `bus_addr`, then go to DATA.
- **DATA:**
  - `wr_ready`=1.
  - Each cycle with `wr_valid`=1 transfers one beat.
  - A cycle with `wr_valid`=0 is a stall: `bus_valid`=0 and the state holds. There is no stall timeout.
  - After beat `len+1`, go to IDLE and pulse `done`.
- `bus_req` stays high from ARBI entry through the last DATA cycle.
- `bus_addr` holds the latched address from ADDRESS entry through the end of DATA. It is 0 otherwise.
- `bus_valid` = (state==DATA) & `wr_valid`.
- `bus_data` = `wr_data` when `bus_valid`=1, else 0.
- `wr_ready` = (state==DATA).
- Commands offered outside IDLE are held off (`cmd_ready`=0). Data offered outside DATA is held off (`wr_ready`=0).

## Timing
- **Reset values:**
  - `bus_state`=IDLE.
  - `cmd_ready`=1.
  - `bus_req`, `bus_valid`, `wr_ready`, `done`, `err` = 0.
  - `bus_addr`, `bus_data` = 0.
- Reset asserted mid-burst forces all of the above immediately (asynchronously) and discards the latched command.
- `bus_state`, `bus_req`, `bus_addr`, `cmd_ready`, `done`, `err` are registered.
- `bus_valid`, `bus_data`, `wr_ready` are combinational from registered state and the `wr_*` inputs.
- With the command accepted at cycle N:
  - ARBI and `bus_req`=1 at N+1.
  - If the grant is seen at cycle G, PREAMBLE runs G+1 .. G+PREAMBLE_CYCLES.
  - ADDRESS is at G+PREAMBLE_CYCLES+1.
  - DATA starts at G+PREAMBLE_CYCLES+2.
- With the last beat at cycle L: IDLE, `done`=1, `bus_req`=0, `cmd_ready`=1 at L+1.
- Minimum no-stall burst, with grant in the first ARBI cycle: 1 + PREAMBLE_CYCLES + 1 + (len+1) cycles from ARBI entry to IDLE.
- A timeout with ARBI entered at cycle A gives IDLE and `err`=1 at A+ARB_TIMEOUT.
- `done` and `err` are never high in the same cycle.
- Back-to-back bursts: a command can be accepted in the same cycle `done` pulses, giving a new ARBI at the next cycle.

## Structure
- Shared package `bus_pkg` holds `state_t` with explicit encodings: IDLE=0, ARBI=1, PREAMBLE=2, ADDRESS=3, DATA=4.
- The monitor and the e checker use the same encodings. Any reorder is a checker failure.
- The package also holds default parameter constants.
- No sub-module: the FSM plus two counters fit in a single module.

## Test plan
- **Basic burst:** after reset, command addr=0x1234, len=3; grant after 2 ARBI cycles; `wr_valid` held 1 with data 0xA0..0xA3.
  - `bus_state` sequence is ARBI×2, PREAMBLE×4, ADDRESS×1, DATA×4, then IDLE.
  - `bus_addr`=0x1234 through DATA.
  - Exactly 4 `bus_valid` cycles carrying 0xA0..0xA3.
  - `done` pulses once.
- **Arbitration timeout:** command issued, `bus_gnt` held 0.
  - IDLE and `err`=1 exactly 32 cycles after ARBI entry.
  - `bus_req` drops with the return to IDLE.
  - No PREAMBLE is entered.
- **Grant in the timeout cycle:** `bus_gnt` first high on ARBI cycle 32 → PREAMBLE is entered and `err` stays 0.
- **Data stalls:** len=1; `wr_valid` pattern in DATA is 1,0,0,1 → DATA lasts 4 cycles, `bus_valid`=1,0,0,1, and `done` follows the 4th cycle.
- **Back-to-back:** a second command (len=0) is held on `cmd_valid` during the first burst.
  - It is accepted in the `done` cycle.
  - ARBI is entered the next cycle.
  - `cmd_ready` is 0 throughout the first burst.
- **Reset mid-DATA:** assert `rst_n`=0 during the 2nd beat.
  - All outputs go to reset values without waiting for a clock edge.
  - After release, a new command runs a full clean sequence.
